// File: rtl/ps2_key_matrix.sv
// PS/2 keyboard to 8x8 key matrix, scanned through the parallel interface.
// Ports:
//   clk_sys, reset        system clock, async active-high reset
//   ps2_clk, ps2_data     raw PS/2 lines (asynchronous)
//   key_clear             synchronous release of all keys
//   scan_sel / scan_ret   active-low row select / active-low column return
//   map_addr / map_data   layout ROM {ext,code} -> {valid,rsvd,row,col}
//   key_event, rx_err     one-cycle status pulses
module ps2_key_matrix #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       key_clear,
    input  logic [7:0] scan_sel,
    output logic [7:0] scan_ret,
    output logic [8:0] map_addr,
    input  logic [7:0] map_data,
    output logic       key_event,
    output logic       rx_err
);

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef enum logic {
        DEC_READY,
        DEC_LOOKUP
    } dec_state_t;

    // Synchronizers and falling-edge detect
    logic [1:0] clk_sync;
    logic [1:0] dat_sync;
    logic       clk_prev;
    logic       fall;
    logic       bit_in;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            clk_prev <= clk_sync[1];
        end
    end

    assign fall   = clk_prev & ~clk_sync[1];
    assign bit_in = dat_sync[1];

    // Receiver
    rx_state_t     rx_state, rx_state_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    rx_byte, rx_byte_n;
    logic          par_bit, par_bit_n;
    logic [TW-1:0] to_cnt, to_cnt_n;
    logic          rx_strobe, rx_strobe_n;
    logic          rx_err_n;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rx_state  <= RX_IDLE;
            bit_cnt   <= '0;
            rx_byte   <= '0;
            par_bit   <= 1'b0;
            to_cnt    <= '0;
            rx_strobe <= 1'b0;
            rx_err    <= 1'b0;
        end else begin
            rx_state  <= rx_state_n;
            bit_cnt   <= bit_cnt_n;
            rx_byte   <= rx_byte_n;
            par_bit   <= par_bit_n;
            to_cnt    <= to_cnt_n;
            rx_strobe <= rx_strobe_n;
            rx_err    <= rx_err_n;
        end
    end

    always_comb begin
        rx_state_n  = rx_state;
        bit_cnt_n   = bit_cnt;
        rx_byte_n   = rx_byte;
        par_bit_n   = par_bit;
        rx_strobe_n = 1'b0;
        rx_err_n    = 1'b0;
        to_cnt_n    = (rx_state == RX_IDLE || fall) ? '0 : to_cnt + 1'b1;

        unique case (rx_state)
            RX_IDLE: begin
                if (fall && !bit_in) begin
                    rx_state_n = RX_DATA;
                    bit_cnt_n  = '0;
                end
            end
            RX_DATA: begin
                if (fall) begin
                    rx_byte_n = {bit_in, rx_byte[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_state_n = RX_PARITY;
                    end
                end
            end
            RX_PARITY: begin
                if (fall) begin
                    par_bit_n  = bit_in;
                    rx_state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (fall) begin
                    // odd parity: XOR over data and parity must be 1
                    if (bit_in && (^{rx_byte, par_bit})) begin
                        rx_strobe_n = 1'b1;
                    end else begin
                        rx_err_n = 1'b1;
                    end
                    rx_state_n = RX_IDLE;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase

        // Silent abort of a stalled partial frame
        if (rx_state != RX_IDLE && !fall &&
            to_cnt == TW'(TIMEOUT_CYC - 1)) begin
            rx_state_n = RX_IDLE;
        end
    end

    // Decoder and key matrix
    dec_state_t      dec_state, dec_state_n;
    logic            ext, ext_n;
    logic            brk, brk_n;
    logic            pend_brk, pend_brk_n;
    logic [8:0]      map_addr_n;
    logic [7:0][7:0] matrix, matrix_n;
    logic            key_event_n;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dec_state <= DEC_READY;
            ext       <= 1'b0;
            brk       <= 1'b0;
            pend_brk  <= 1'b0;
            map_addr  <= '0;
            matrix    <= '0;
            key_event <= 1'b0;
        end else begin
            dec_state <= dec_state_n;
            ext       <= ext_n;
            brk       <= brk_n;
            pend_brk  <= pend_brk_n;
            map_addr  <= map_addr_n;
            matrix    <= matrix_n;
            key_event <= key_event_n;
        end
    end

    always_comb begin
        dec_state_n = dec_state;
        ext_n       = ext;
        brk_n       = brk;
        pend_brk_n  = pend_brk;
        map_addr_n  = map_addr;
        matrix_n    = matrix;
        key_event_n = 1'b0;

        unique case (dec_state)
            DEC_READY: begin
                if (rx_strobe) begin
                    if (rx_byte == 8'hE0) begin
                        ext_n = 1'b1;
                    end else if (rx_byte == 8'hF0) begin
                        brk_n = 1'b1;
                    end else begin
                        map_addr_n  = {ext, rx_byte};
                        pend_brk_n  = brk;
                        ext_n       = 1'b0;
                        brk_n       = 1'b0;
                        dec_state_n = DEC_LOOKUP;
                    end
                end
            end
            DEC_LOOKUP: begin
                if (map_data[7]) begin
                    matrix_n[map_data[5:3]][map_data[2:0]] = ~pend_brk;
                    key_event_n = 1'b1;
                end
                dec_state_n = DEC_READY;
            end
            default: dec_state_n = DEC_READY;
        endcase

        if (rx_err) begin
            ext_n = 1'b0;
            brk_n = 1'b0;
        end

        // Clear overrides any write landing in the same cycle
        if (key_clear) begin
            matrix_n    = '0;
            ext_n       = 1'b0;
            brk_n       = 1'b0;
            pend_brk_n  = 1'b0;
            key_event_n = 1'b0;
        end
    end

    // Scan response: selected rows OR together, active-low both ways
    always_comb begin
        scan_ret = 8'hFF;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (!scan_sel[r] && matrix[r][c]) begin
                    scan_ret[c] = 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_matrix.sv
// Directed bench for ps2_key_matrix: PS/2 frames in, matrix scans out.
module tb_ps2_key_matrix;

    localparam int TO = 200;

    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       key_clear = 1'b0;
    logic [7:0] scan_sel = 8'hFF;
    logic [7:0] scan_ret;
    logic [8:0] map_addr;
    logic [7:0] map_data;
    logic       key_event;
    logic       rx_err;

    int checks = 0;
    int errors = 0;
    int ev_cnt = 0;
    int err_cnt = 0;

    ps2_key_matrix #(.TIMEOUT_CYC(TO)) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .key_clear(key_clear),
        .scan_sel (scan_sel),
        .scan_ret (scan_ret),
        .map_addr (map_addr),
        .map_data (map_data),
        .key_event(key_event),
        .rx_err   (rx_err)
    );

    always #5 clk_sys = ~clk_sys;

    // Layout ROM: map_addr is its address register, array read is direct
    function automatic logic [7:0] rom(input logic [8:0] a);
        case (a)
            9'h01C:  rom = 8'h91;
            9'h175:  rom = 8'hBF;
            9'h075:  rom = 8'h9D;
            9'h016:  rom = 8'h80;
            9'h01E:  rom = 8'h8B;
            default: rom = 8'h00;
        endcase
    endfunction

    always_comb map_data = rom(map_addr);

    always @(posedge clk_sys) begin
        if (key_event === 1'b1) ev_cnt++;
        if (rx_err === 1'b1) err_cnt++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        wait_cyc(4);
        ps2_clk = 1'b0;
        wait_cyc(8);
        ps2_clk = 1'b1;
        wait_cyc(4);
    endtask

    task automatic send(input logic [7:0] b, input logic bad_par,
                        input logic bad_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(bad_par ? ^b : ~^b);
        ps2_bit(bad_stop ? 1'b0 : 1'b1);
        ps2_data = 1'b1;
        wait_cyc(20);
    endtask

    task automatic key(input logic [7:0] b);
        send(b, 1'b0, 1'b0);
    endtask

    task automatic scan(input string tag, input logic [7:0] sel,
                        input logic [7:0] exp);
        scan_sel = sel;
        #1;
        chk(tag, 32'(scan_ret), 32'(exp));
    endtask

    initial begin
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(2);
        scan("rst_scan", 8'h00, 8'hFF);
        chk("rst_addr", 32'(map_addr), 32'h000);
        chk("rst_kev", 32'(key_event), 32'd0);
        chk("rst_err", 32'(rx_err), 32'd0);

        key(8'h1C);
        chk("press_ev", ev_cnt, 1);
        chk("press_addr", 32'(map_addr), 32'h01C);
        scan("press_r2", 8'hFB, 8'hFD);
        scan("press_r0", 8'hFE, 8'hFF);

        key(8'hF0);
        key(8'h1C);
        chk("rel_ev", ev_cnt, 2);
        scan("rel_r2", 8'hFB, 8'hFF);
        key(8'h1C);
        chk("brk_clr_ev", ev_cnt, 3);
        scan("brk_clr", 8'hFB, 8'hFD);
        key(8'hF0);
        key(8'h1C);
        scan("rel2_r2", 8'hFB, 8'hFF);

        key(8'hE0);
        key(8'h75);
        chk("ext_addr", 32'(map_addr), 32'h175);
        chk("ext_ev", ev_cnt, 5);
        scan("ext_r7", 8'h7F, 8'h7F);
        key(8'h75);
        chk("plain_addr", 32'(map_addr), 32'h075);
        scan("plain_r3", 8'hF7, 8'hDF);

        key(8'hE0);
        send(8'h75, 1'b1, 1'b0);
        chk("par_err", err_cnt, 1);
        chk("par_ev", ev_cnt, 6);
        key(8'h75);
        chk("par_ext_clr", 32'(map_addr), 32'h075);
        key(8'h22);
        chk("unmap_addr", 32'(map_addr), 32'h022);
        chk("unmap_ev", ev_cnt, 7);
        key(8'hE0);
        send(8'h75, 1'b0, 1'b1);
        chk("stop_err", err_cnt, 2);
        chk("stop_ev", ev_cnt, 7);
        key(8'h75);
        chk("stop_ext_clr", 32'(map_addr), 32'h075);
        scan("err_matrix", 8'h00, 8'h5F);

        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1);
        ps2_data = 1'b1;
        wait_cyc(TO + 60);
        chk("to_noerr", err_cnt, 2);
        key(8'h1C);
        chk("to_addr", 32'(map_addr), 32'h01C);
        chk("to_ev", ev_cnt, 9);
        scan("to_r2", 8'hFB, 8'hFD);

        key_clear = 1'b1;
        wait_cyc(1);
        key_clear = 1'b0;
        wait_cyc(1);
        scan("clr_all", 8'h00, 8'hFF);
        key(8'h16);
        key(8'h1E);
        chk("multi_ev", ev_cnt, 11);
        scan("multi", 8'hFC, 8'hF6);
        scan("multi_r1", 8'hFD, 8'hF7);
        key_clear = 1'b1;
        wait_cyc(1);
        key_clear = 1'b0;
        wait_cyc(1);
        scan("multi_clr", 8'hFC, 8'hFF);

        key(8'h1C);
        scan("pre_rst", 8'hFB, 8'hFD);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b0);
        ps2_data = 1'b1;
        reset = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(2);
        scan("mid_rst", 8'h00, 8'hFF);
        chk("mid_rst_addr", 32'(map_addr), 32'h000);
        key(8'h1C);
        chk("post_rst_ev", ev_cnt, 13);
        scan("post_rst", 8'hFB, 8'hFD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
